cr_osf_ob_arb: RTL and testbench

//  Frame-aware weighted round-robin arbiter for the OSF outbound path. It shares one outbound FIFO

---
 rtl/cr_osf_ob_arb_pkg.sv | 32 +++
 rtl/cr_osf_ob_arb_rr_pick.sv | 27 ++
 rtl/cr_osf_ob_arb.sv | 190 +++++++++++++++++++
 tb/tb_cr_osf_ob_arb.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_osf_ob_arb_pkg.sv
// Shared types for the OSF outbound arbiter: FSM states, TLV marker bit positions and the
// datapath beat carried between the per-source FIFOs and ob_fifo.
package cr_osf_ob_arb_pkg;

   typedef enum logic {
      OSF_ARB_IDLE = 1'b0,
      OSF_ARB_XFER = 1'b1
   } osf_ob_arb_st_e;

   localparam int SOT_BIT   = 0;
   localparam int EOT_BIT   = 1;

   localparam int DP_DATA_W = 64;
   localparam int DP_KEEP_W = DP_DATA_W / 8;
   localparam int DP_USER_W = 8;

   typedef struct packed {
      logic [DP_DATA_W-1:0] tdata;
      logic [DP_KEEP_W-1:0] tkeep;
      logic [DP_USER_W-1:0] tuser;
      logic                 tlast;
   } axi4s_dp_bus_t;

   function automatic logic is_sot(input axi4s_dp_bus_t b);
      return b.tuser[SOT_BIT];
   endfunction

   function automatic logic is_eot(input axi4s_dp_bus_t b);
      return b.tuser[EOT_BIT];
   endfunction

endpackage

// File: rtl/cr_osf_ob_arb_rr_pick.sv
// Rotate-priority picker: first set bit of eligible at or after ptr, wrapping modulo N.
// Purely combinational; no backpressure of its own.
module cr_osf_rr_pick
   import cr_osf_ob_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] ptr,
   output logic          vld,
   output logic [IW-1:0] idx
);

   // Walk from the farthest position back to ptr so the nearest eligible entry wins.
   always_comb begin
      vld = 1'b0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (eligible[(int'(ptr) + k) % N]) begin
            vld = 1'b1;
            idx = IW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/cr_osf_ob_arb.sv
// Frame-aware weighted round-robin arbiter onto one ob_fifo write port; one bubble per grant, zero-latency beats.
// Stalls (no pop, no write) on ob_fifo_full or empty granted source. Optional counters: CR_OSF_OB_ARB_STATS_EN.
module cr_osf_ob_arb
   import cr_osf_ob_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WGT_W = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  axi4s_dp_bus_t [N_REQ-1:0]        req_fifo_rdata,
   input  logic [N_REQ-1:0]                 req_fifo_empty,
   output logic [N_REQ-1:0]                 req_fifo_rd,
   input  logic                             ob_fifo_full,
   output logic                             ob_fifo_wr,
   output axi4s_dp_bus_t                    ob_fifo_wdata,
   input  logic [N_REQ-1:0]                 cfg_req_en,
   input  logic [N_REQ-1:0][WGT_W-1:0]      cfg_weight,
   output logic                             arb_busy,
   output logic [$clog2(N_REQ)-1:0]         arb_grant_id,
   output logic                             arb_err_sot
`ifdef CR_OSF_OB_ARB_STATS_EN
   ,
   input  logic                             stat_clr,
   output logic [N_REQ-1:0][31:0]           stat_tlv_cnt,
   output logic [31:0]                      stat_stall_cnt
`endif
);

   localparam int IW = $clog2(N_REQ);

   osf_ob_arb_st_e   state_q, state_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]    grant_q, grant_d;
   logic [WGT_W-1:0] tlv_cnt_q, tlv_cnt_d;
   logic             in_tlv_q, in_tlv_d;
   logic             at_bnd_q, at_bnd_d;
   logic             busy_q, busy_d;
   logic             err_sot_q, err_sot_d;

   logic [N_REQ-1:0] eligible;
   logic             pick_vld;
   logic [IW-1:0]    pick_idx;

   assign eligible = cfg_req_en & ~req_fifo_empty;

   cr_osf_rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_pick (
      .eligible (eligible),
      .ptr      (rr_ptr_q),
      .vld      (pick_vld),
      .idx      (pick_idx)
   );

   logic             xfer;
   logic             src_empty;
   logic             grant_en;
   logic             beat;
   logic             beat_sot;
   logic             beat_eot;
   axi4s_dp_bus_t    head;
   logic [WGT_W-1:0] wgt_eff;
   logic [WGT_W:0]   cnt_inc;
   logic             tlv_quota;
   logic [IW-1:0]    grant_nxt;

   always_comb begin
      xfer      = (state_q == OSF_ARB_XFER);
      head      = req_fifo_rdata[grant_q];
      src_empty = req_fifo_empty[grant_q];
      grant_en  = cfg_req_en[grant_q];
      beat      = xfer & ~src_empty & ~ob_fifo_full;
      beat_sot  = is_sot(head);
      beat_eot  = is_eot(head);
      wgt_eff   = (cfg_weight[grant_q] == '0) ? WGT_W'(1) : cfg_weight[grant_q];
      cnt_inc   = {1'b0, tlv_cnt_q} + (WGT_W+1)'(1);
      tlv_quota = (cnt_inc >= {1'b0, wgt_eff});
      grant_nxt = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      tlv_cnt_d = tlv_cnt_q;
      in_tlv_d  = in_tlv_q;
      at_bnd_d  = 1'b0;
      err_sot_d = 1'b0;
      case (state_q)
         OSF_ARB_IDLE: begin
            if (pick_vld) begin
               state_d   = OSF_ARB_XFER;
               grant_d   = pick_idx;
               tlv_cnt_d = '0;
            end
         end
         OSF_ARB_XFER: begin
            // at_bnd_q marks the cycle after an EOT that left quota: an empty source ends the grant there.
            if (at_bnd_q && src_empty) begin
               state_d  = OSF_ARB_IDLE;
               rr_ptr_d = grant_nxt;
            end else if (beat) begin
               err_sot_d = beat_sot & in_tlv_q;
               if (beat_eot) begin
                  in_tlv_d = 1'b0;
               end else if (beat_sot) begin
                  in_tlv_d = 1'b1;
               end
               if (beat_eot) begin
                  if (tlv_quota || !grant_en) begin
                     state_d  = OSF_ARB_IDLE;
                     rr_ptr_d = grant_nxt;
                  end else begin
                     tlv_cnt_d = cnt_inc[WGT_W-1:0];
                     at_bnd_d  = 1'b1;
                  end
               end
            end
         end
         default: state_d = OSF_ARB_IDLE;
      endcase
      busy_d = (state_d == OSF_ARB_XFER);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= OSF_ARB_IDLE;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         tlv_cnt_q <= '0;
         in_tlv_q  <= 1'b0;
         at_bnd_q  <= 1'b0;
         busy_q    <= 1'b0;
         err_sot_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         tlv_cnt_q <= tlv_cnt_d;
         in_tlv_q  <= in_tlv_d;
         at_bnd_q  <= at_bnd_d;
         busy_q    <= busy_d;
         err_sot_q <= err_sot_d;
      end
   end

   assign ob_fifo_wr    = ~rst & beat;
   assign req_fifo_rd   = (~rst & beat) ? (N_REQ'(1) << grant_q) : '0;
   assign ob_fifo_wdata = (~rst & xfer) ? head : '0;
   assign arb_busy      = busy_q;
   assign arb_grant_id  = grant_q;
   assign arb_err_sot   = err_sot_q;

`ifdef CR_OSF_OB_ARB_STATS_EN
   logic [N_REQ-1:0][31:0] stat_tlv_q, stat_tlv_d;
   logic [31:0]            stat_stall_q, stat_stall_d;

   always_comb begin
      stat_tlv_d   = stat_tlv_q;
      stat_stall_d = stat_stall_q;
      if (stat_clr) begin
         stat_tlv_d   = '0;
         stat_stall_d = '0;
      end else begin
         if (beat && beat_eot) begin
            stat_tlv_d[grant_q] = stat_tlv_q[grant_q] + 32'd1;
         end
         if (xfer && ob_fifo_full) begin
            stat_stall_d = stat_stall_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_tlv_q   <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_tlv_q   <= stat_tlv_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_tlv_cnt   = stat_tlv_q;
   assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_cr_osf_ob_arb.sv
// Bench for cr_osf_ob_arb: queue-backed source FIFOs, TLV-level arbitration model feeding a scoreboard.
// Covers the counter outputs when CR_OSF_OB_ARB_STATS_EN is defined.
module tb_cr_osf_ob_arb;
   import cr_osf_ob_arb_pkg::*;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst;
   axi4s_dp_bus_t [N-1:0]  req_fifo_rdata;
   logic [N-1:0]           req_fifo_empty;
   logic [N-1:0]           req_fifo_rd;
   logic                   ob_fifo_full;
   logic                   ob_fifo_wr;
   axi4s_dp_bus_t          ob_fifo_wdata;
   logic [N-1:0]           cfg_req_en;
   logic [N-1:0][W-1:0]    cfg_weight;
   logic                   arb_busy;
   logic [IW-1:0]          arb_grant_id;
   logic                   arb_err_sot;
`ifdef CR_OSF_OB_ARB_STATS_EN
   logic                   stat_clr;
   logic [N-1:0][31:0]     stat_tlv_cnt;
   logic [31:0]            stat_stall_cnt;
`endif

   cr_osf_ob_arb #(.N_REQ(N), .WGT_W(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_fifo_rdata (req_fifo_rdata),
      .req_fifo_empty (req_fifo_empty),
      .req_fifo_rd    (req_fifo_rd),
      .ob_fifo_full   (ob_fifo_full),
      .ob_fifo_wr     (ob_fifo_wr),
      .ob_fifo_wdata  (ob_fifo_wdata),
      .cfg_req_en     (cfg_req_en),
      .cfg_weight     (cfg_weight),
      .arb_busy       (arb_busy),
      .arb_grant_id   (arb_grant_id),
      .arb_err_sot    (arb_err_sot)
`ifdef CR_OSF_OB_ARB_STATS_EN
      ,
      .stat_clr       (stat_clr),
      .stat_tlv_cnt   (stat_tlv_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   typedef struct {
      axi4s_dp_bus_t w;
      int            src;
   } exp_t;

   axi4s_dp_bus_t src_q[N][$];
   axi4s_dp_bus_t mdl_q[N][$];
   exp_t          exp_q[$];
   int            wr_cyc_q[$];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int wr_cnt     = 0;
   int err_cyc    = 0;
   int mptr       = 0;
   int full_mode  = 0;   // 0 never, 1 toggle, 2 random, 3 driven by the sequence

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic void update_src();
      for (int i = 0; i < N; i++) begin
         req_fifo_empty[i] = (src_q[i].size() == 0);
         req_fifo_rdata[i] = (src_q[i].size() == 0) ? '0 : src_q[i][0];
      end
   endfunction

   task automatic push_tlv(input int s, input int len, input int sot_at);
      axi4s_dp_bus_t w;
      for (int b = 0; b < len; b++) begin
         w         = '0;
         w.tdata   = {$urandom, $urandom};
         w.tkeep   = '1;
         w.tuser[SOT_BIT] = (b == 0) || (b == sot_at);
         w.tuser[EOT_BIT] = (b == len - 1);
         w.tlast   = (b == len - 1);
         src_q[s].push_back(w);
         mdl_q[s].push_back(w);
      end
   endtask

   // Reference: whole TLVs per grant, up to max(weight,1) or until the source runs dry.
   task automatic model_run(input int max_g, input logic [N-1:0] en);
      int   g, found, wgt, t;
      bit   done, eot;
      exp_t e;
      g    = 0;
      done = 0;
      while (!done && g < max_g) begin
         found = -1;
         for (int k = 0; k < N; k++) begin
            if (found < 0 && en[(mptr + k) % N] && mdl_q[(mptr + k) % N].size() > 0)
               found = (mptr + k) % N;
         end
         if (found < 0) begin
            done = 1;
         end else begin
            wgt = (cfg_weight[found] == 0) ? 1 : int'(cfg_weight[found]);
            t   = 0;
            while (t < wgt && mdl_q[found].size() > 0) begin
               eot = 0;
               while (!eot && mdl_q[found].size() > 0) begin
                  e.w   = mdl_q[found].pop_front();
                  e.src = found;
                  exp_q.push_back(e);
                  eot   = e.w.tuser[EOT_BIT];
               end
               t++;
            end
            mptr = (found + 1) % N;
            g++;
         end
      end
   endtask

   task automatic clear_srcs();
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         mdl_q[i].delete();
      end
      update_src();
   endtask

   task automatic wait_drain(input string nm, input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({nm, "_drain_left"}, exp_q.size(), 0);
      chk({nm, "_idle_busy"}, arb_busy, 0);
      exp_q.delete();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_wr(input string nm, input int n0, input int k, input int budget);
      int n;
      n = 0;
      while ((wr_cnt - n0) < k && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      if ((wr_cnt - n0) < k) chk({nm, "_wait_timeout"}, wr_cnt - n0, k);
   endtask

   // Source FIFO model and ob_fifo_full driver: pops whatever rd showed in the cycle just ended.
   initial begin
      logic [N-1:0] rd_s;
      forever begin
         @(negedge clk);
         rd_s = req_fifo_rd;
         @(posedge clk);
         cyc++;
         #1;
         for (int i = 0; i < N; i++)
            if (rd_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         case (full_mode)
            0: ob_fifo_full = 1'b0;
            1: ob_fifo_full = ~ob_fifo_full;
            2: ob_fifo_full = ($urandom_range(0, 2) == 0);
            default: ;
         endcase
         update_src();
      end
   end

   // Monitor: compares every write against the scoreboard head, and rd against wr each cycle.
   initial begin
      logic [N-1:0] exp_rd;
      exp_t         e;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_rd", req_fifo_rd, 0);
            chk("rst_wr", ob_fifo_wr, 0);
            chk("rst_wdata", ob_fifo_wdata, 0);
         end else begin
            exp_rd = ob_fifo_wr ? (N'(1) << arb_grant_id) : '0;
            chk("rd_vs_wr", req_fifo_rd, exp_rd);
            if (arb_err_sot) err_cyc++;
            if (ob_fifo_wr) begin
               wr_cnt++;
               wr_cyc_q.push_back(cyc);
               if (exp_q.size() == 0) begin
                  chk("unexpected_wr", ob_fifo_wdata, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("wdata", ob_fifo_wdata, e.w);
                  chk("grant_id", arb_grant_id, e.src);
               end
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded time limit, got %0d cycles expected < 80000", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, n0, e0;
      logic [N-1:0] en_r;
      rst          = 1'b1;
      ob_fifo_full = 1'b0;
      cfg_req_en   = '1;
      for (int i = 0; i < N; i++) cfg_weight[i] = W'(1);
`ifdef CR_OSF_OB_ARB_STATS_EN
      stat_clr     = 1'b0;
`endif
      update_src();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", arb_busy, 0);
      chk("reset_grant", arb_grant_id, 0);
      chk("reset_err", arb_err_sot, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;

      // Single source, weight 2: bubble, 8 beats, bubble, 4 beats.
      cfg_weight[0] = W'(2);
      c0 = cyc;
      n0 = wr_cnt;
      for (int t = 0; t < 3; t++) push_tlv(0, 4, -1);
      update_src();
      model_run(100, cfg_req_en);
      wait_drain("t1", 100);
      chk("t1_wr_cnt", wr_cnt - n0, 12);
      if (wr_cnt - n0 >= 12) begin
         chk("t1_first_wr_cyc", wr_cyc_q[n0] - c0, 1);
         chk("t1_8th_wr_cyc", wr_cyc_q[n0 + 7] - c0, 8);
         chk("t1_9th_wr_cyc", wr_cyc_q[n0 + 8] - c0, 10);
         chk("t1_last_wr_cyc", wr_cyc_q[n0 + 11] - c0, 13);
      end

      // All sources, weight 1, two 2-beat TLVs each: strict rotation.
      for (int i = 0; i < N; i++) cfg_weight[i] = W'(1);
      for (int t = 0; t < 2; t++)
         for (int i = 0; i < N; i++) push_tlv(i, 2, -1);
      update_src();
      model_run(100, cfg_req_en);
      wait_drain("t2", 200);

      // Full toggling each cycle during a 6-beat TLV.
      full_mode = 1;
      n0 = wr_cnt;
      push_tlv(2, 6, -1);
      update_src();
      model_run(100, cfg_req_en);
      wait_drain("t3", 100);
      chk("t3_wr_cnt", wr_cnt - n0, 6);
      full_mode = 0;

      // Disable req1 mid-TLV: its TLV completes, then it is skipped.
      n0 = wr_cnt;
      push_tlv(1, 4, -1);
      push_tlv(1, 4, -1);
      update_src();
      model_run(1, cfg_req_en);
      wait_wr("t4", n0, 2, 50);
      cfg_req_en[1] = 1'b0;
      for (int t = 0; t < 2; t++) begin
         push_tlv(2, 4, -1);
         push_tlv(3, 4, -1);
      end
      update_src();
      model_run(100, cfg_req_en);
      wait_drain("t4", 200);
      chk("t4_req1_left", src_q[1].size(), 4);
      clear_srcs();
      cfg_req_en = '1;

      // SOT inside a TLV is flagged once and still forwarded.
      e0 = err_cyc;
      push_tlv(0, 5, 2);
      update_src();
      model_run(100, cfg_req_en);
      wait_drain("t5", 100);
      chk("t5_err_sot_cycles", err_cyc - e0, 1);

      // Reset mid-TLV abandons the rest of it.
      n0 = wr_cnt;
      push_tlv(1, 6, -1);
      update_src();
      model_run(100, cfg_req_en);
      wait_wr("t5r", n0, 3, 50);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t5r_busy", arb_busy, 0);
      chk("t5r_grant", arb_grant_id, 0);
      chk("t5r_abandoned", exp_q.size(), 3);
      chk("t5r_src_left", src_q[1].size(), 3);
      @(posedge clk);
      #2;
      rst = 1'b0;
      exp_q.delete();
      clear_srcs();
      mptr = 0;
      repeat (2) @(posedge clk);
      #2;

      // Randomised rounds against the reference model.
      e0 = err_cyc;
      for (int r = 0; r < 16; r++) begin
         full_mode = (r % 2 == 0) ? 2 : 0;
         en_r = N'($urandom_range(0, (1 << N) - 1));
         cfg_req_en = en_r;
         for (int i = 0; i < N; i++) cfg_weight[i] = W'($urandom_range(0, 3));
         for (int i = 0; i < N; i++) begin
            int ntlv;
            ntlv = $urandom_range(0, 3);
            for (int t = 0; t < ntlv; t++) push_tlv(i, $urandom_range(1, 5), -1);
         end
         update_src();
         model_run(1000, en_r);
         wait_drain("rand", 2000);
         clear_srcs();
      end
      full_mode = 0;
      cfg_req_en = '1;
      chk("rand_err_sot_cycles", err_cyc - e0, 0);

`ifdef CR_OSF_OB_ARB_STATS_EN
      stat_clr = 1'b1;
      @(posedge clk);
      #2;
      stat_clr = 1'b0;
      full_mode = 3;
      ob_fifo_full = 1'b0;
      cfg_weight[2] = W'(8);
      n0 = wr_cnt;
      for (int t = 0; t < 5; t++) push_tlv(2, 2, -1);
      update_src();
      model_run(100, cfg_req_en);
      wait_wr("t6", n0, 2, 50);
      ob_fifo_full = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      ob_fifo_full = 1'b0;
      wait_drain("t6", 100);
      full_mode = 0;
      chk("t6_stat_tlv2", stat_tlv_cnt[2], 5);
      chk("t6_stat_stall", stat_stall_cnt, 3);
      stat_clr = 1'b1;
      @(posedge clk);
      #2;
      stat_clr = 1'b0;
      @(negedge clk);
      chk("t6_clr_tlv2", stat_tlv_cnt[2], 0);
      chk("t6_clr_stall", stat_stall_cnt, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
